// File: rtl/go_pkg.sv
// Shared constants for the Go board datapath.
//   Cell encodings stored in checkerboard_state_ram, move response status
//   codes, board geometry and the RAM address/data widths.
package go_pkg;

    localparam int BOARD_DIM = 8;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 2;

    // Cell contents: 00 empty, 01 black, 10 white, 11 reserved.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Move response status.
    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_OCCUPIED = 2'b01;
    localparam logic [1:0] ST_BLOCKED  = 2'b10;

    // Colour that moves after the given one.
    function automatic logic [1:0] other_colour(input logic [1:0] c);
        return (c == CELL_BLACK) ? CELL_WHITE : CELL_BLACK;
    endfunction

endpackage

// File: rtl/move_placer.sv
// move_placer: move-entry stage for the 8x8 board in checkerboard_state_ram.
//   Accepts one move request (placement or pass) at a time, checks the target
//   cell through the asynchronous RAM read port, writes the current player's
//   stone into an empty cell, and tracks turn, move count and game end
//   (two consecutive passes). Stays off the shared write port while inhibit
//   (board clear in progress) is high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               new-game pulse, same effect as rst
//   inhibit             board clear in progress; no write, no new request
//   req_valid/req_ready request handshake; req_row/req_col/req_pass payload
//   rsp_valid/rsp_status one-cycle response pulse, status OK/OCCUPIED/BLOCKED
//   rd_addr/rd_data     RAM read port (asynchronous read)
//   ram_we/ram_addr/ram_data  RAM write port towards the external write mux
//   turn, move_count, game_over  game status
module move_placer #(
    parameter int ADDR_W = go_pkg::ADDR_W,
    parameter int DATA_W = go_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inhibit,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_row,
    input  logic [2:0]        req_col,
    input  logic              req_pass,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [1:0]        turn,
    output logic [7:0]        move_count,
    output logic              game_over
);
    import go_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q;
    state_t      state_nxt;

    logic        pass_q;
    logic [1:0]  status_q;
    logic [1:0]  turn_q;
    logic [7:0]  count_q;
    logic [1:0]  pass_cnt_q;

    logic        accept;
    logic        commit_pass;
    logic        commit_place;
    logic        status_ld;
    logic [1:0]  status_nxt;
    logic        load_wr;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next state and per-state decisions
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt    = state_q;
        req_ready    = 1'b0;
        accept       = 1'b0;
        commit_pass  = 1'b0;
        commit_place = 1'b0;
        status_ld    = 1'b0;
        status_nxt   = ST_OK;
        load_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = ~inhibit & ~game_over;
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (inhibit) begin
                    status_ld  = 1'b1;
                    status_nxt = ST_BLOCKED;
                    state_nxt  = S_RESP;
                end else if (pass_q) begin
                    status_ld   = 1'b1;
                    status_nxt  = ST_OK;
                    commit_pass = 1'b1;
                    state_nxt   = S_RESP;
                end else if (rd_data != '0) begin
                    status_ld  = 1'b1;
                    status_nxt = ST_OCCUPIED;
                    state_nxt  = S_RESP;
                end else begin
                    load_wr   = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                status_ld = 1'b1;
                if (inhibit) begin
                    status_nxt = ST_BLOCKED;
                end else begin
                    status_nxt   = ST_OK;
                    commit_place = 1'b1;
                end
                state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Move registers and game status
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pass_q     <= 1'b0;
            status_q   <= ST_OK;
            rd_addr    <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            turn_q     <= CELL_BLACK;
            count_q    <= '0;
            pass_cnt_q <= '0;
        end else begin
            if (accept) begin
                // rd_addr doubles as the latched target address.
                rd_addr <= ADDR_W'({req_row, req_col});
                pass_q  <= req_pass;
            end
            if (status_ld) begin
                status_q <= status_nxt;
            end
            // Write port is set up on entry to WRITE; turn cannot change
            // between CHECK and WRITE, so the stone colour is final here.
            if (load_wr) begin
                ram_addr <= rd_addr;
                ram_data <= DATA_W'(turn_q);
            end
            if (commit_pass || commit_place) begin
                turn_q <= other_colour(turn_q);
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end
            if (commit_pass) begin
                if (pass_cnt_q != 2'b11) begin
                    pass_cnt_q <= pass_cnt_q + 2'd1;
                end
            end else if (commit_place) begin
                pass_cnt_q <= '0;
            end
        end
    end

    // Write enable is combinational so inhibit, rst and clear cut it off
    // within the same cycle.
    assign ram_we     = (state_q == S_WRITE) & ~inhibit & ~rst & ~clear;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = status_q;
    assign turn       = turn_q;
    assign move_count = count_q;
    // Counter reaches 2 only through consecutive passes; bit 1 marks it.
    assign game_over  = pass_cnt_q[1];

endmodule
